// File: rtl/four_bit_up_down_counter.sv
// Synchronous up/down counter with synchronous reset, parallel load, hold and
// modulo wrap-around. Tc flags the cycle in which the next edge would wrap.
module four_bit_up_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic             Count_en,
  input  logic             Up,
  input  logic [WIDTH-1:0] Count_in,
  output logic [WIDTH-1:0] Count_out,
  output logic             Tc
);

  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] cnt_next;
  logic             at_max;
  logic             at_min;

  // Load beats counting; reset is handled in the register itself.
  always_comb begin
    cnt_next = cnt_reg;
    if (Load) begin
      cnt_next = Count_in;
    end else if (Count_en) begin
      if (Up) begin
        cnt_next = cnt_reg + 1'b1;
      end else begin
        cnt_next = cnt_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign at_max    = &cnt_reg;
  assign at_min    = ~|cnt_reg;
  assign Count_out = cnt_reg;
  // Only a real counting step can wrap, so Load and Reset suppress the flag.
  assign Tc        = Count_en & ~Load & ~Reset & ((Up & at_max) | (~Up & at_min));

endmodule

// File: tb/tb_four_bit_up_down_counter.sv
// Bench for four_bit_up_down_counter: directed vector table, hand-written
// corner sequences, then randomized stimulus against an arithmetic model.
module tb_four_bit_up_down_counter;

  localparam int WIDTH = 4;
  localparam int MOD   = 1 << WIDTH;

  logic             Clk = 1'b0;
  logic             Reset = 1'b0;
  logic             Load = 1'b0;
  logic             Count_en = 1'b0;
  logic             Up = 1'b0;
  logic [WIDTH-1:0] Count_in = '0;
  logic [WIDTH-1:0] Count_out;
  logic             Tc;

  int checks = 0;
  int errors = 0;
  int model  = 0;

  four_bit_up_down_counter #(.WIDTH(WIDTH)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Load      (Load),
    .Count_en  (Count_en),
    .Up        (Up),
    .Count_in  (Count_in),
    .Count_out (Count_out),
    .Tc        (Tc)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic             rst;
    logic             ld;
    logic             ce;
    logic             up;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] exp_out;
    logic             exp_tc;
  } vec_t;

  vec_t vecs [13];

  // Next count from the behavioural rules, with plain modular arithmetic.
  function automatic int model_next(input int cur, input logic rst, input logic ld,
                                    input logic ce, input logic up, input int din);
    if (rst) return 0;
    if (ld) return din;
    if (ce) return up ? (cur + 1) % MOD : (cur + MOD - 1) % MOD;
    return cur;
  endfunction

  function automatic logic model_tc(input int cur, input logic rst, input logic ld,
                                    input logic ce, input logic up);
    return ce && !ld && !rst && ((up && cur == MOD - 1) || (!up && cur == 0));
  endfunction

  // Apply one cycle: check Tc before the edge, Count_out one step after it.
  task automatic step(input string name, input logic rst, input logic ld, input logic ce,
                      input logic up, input logic [WIDTH-1:0] din,
                      input logic [WIDTH-1:0] exp_out, input logic exp_tc);
    Reset    = rst;
    Load     = ld;
    Count_en = ce;
    Up       = up;
    Count_in = din;
    #1;
    checks++;
    if (Tc !== exp_tc) begin
      errors++;
      $display("FAIL %s tc: got %b want %b", name, Tc, exp_tc);
    end
    @(posedge Clk);
    model = model_next(model, rst, ld, ce, up, int'(din));
    #1;
    checks++;
    if (Count_out !== exp_out) begin
      errors++;
      $display("FAIL %s out: got %0d want %0d", name, Count_out, exp_out);
    end
    $display("%s rst=%b ld=%b ce=%b up=%b din=%0d -> out=%0d tc_before=%b",
             name, rst, ld, ce, up, din, Count_out, exp_tc);
  endtask

  initial begin
    //             rst   ld    ce    up    din    out    tc
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd5,  4'd0,  1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd10, 4'd10, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd3,  4'd10, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd3,  4'd10, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd3,  4'd10, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd15, 4'd15, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd0,  1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd15, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd14, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  4'd14, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd0,  1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd9,  4'd0,  1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd9,  4'd15, 1'b1};

    #2;
    for (int i = 0; i < 13; i++) begin
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].ld, vecs[i].ce, vecs[i].up,
           vecs[i].din, vecs[i].exp_out, vecs[i].exp_tc);
    end

    // Count up 16 edges from 10: 11..15, 0..10; Tc only while at 15.
    step("load10_up", 1'b0, 1'b1, 1'b0, 1'b0, 4'd10, 4'd10, 1'b0);
    for (int i = 0; i < 16; i++) begin
      int cur;
      int nxt;
      cur = (10 + i) % 16;
      nxt = (11 + i) % 16;
      step($sformatf("up%0d", i), 1'b0, 1'b0, 1'b1, 1'b1, 4'd0,
           WIDTH'(nxt), cur == 15);
    end

    // Count down 16 edges from 10: 9..0, 15..10; Tc only while at 0.
    for (int i = 0; i < 16; i++) begin
      int cur;
      int nxt;
      cur = (10 - i + 16) % 16;
      nxt = (9 - i + 16) % 16;
      step($sformatf("down%0d", i), 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,
           WIDTH'(nxt), cur == 0);
    end

    // Load while counting up at 7: loaded value wins, no increment.
    step("ld7", 1'b0, 1'b1, 1'b0, 1'b1, 4'd7, 4'd7, 1'b0);
    step("ld_over_cnt", 1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 4'd3, 1'b0);
    step("after_ld", 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd4, 1'b0);

    // Reset mid-count at 5, then counting resumes from 0.
    step("to5", 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd5, 1'b0);
    step("rst_mid", 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0);
    step("resume1", 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0);
    step("resume2", 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd2, 1'b0);
    // Direction change takes effect on the very next edge.
    step("dir_flip", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0);

    // Randomized stimulus against the arithmetic model.
    for (int i = 0; i < 300; i++) begin
      logic             r;
      logic             l;
      logic             c;
      logic             u;
      logic [WIDTH-1:0] d;
      int               nxt;
      r = ($urandom_range(0, 19) == 0);
      l = ($urandom_range(0, 7) == 0);
      c = ($urandom_range(0, 3) != 0);
      u = 1'($urandom_range(0, 1));
      d = WIDTH'($urandom_range(0, MOD - 1));
      nxt = model_next(model, r, l, c, u, int'(d));
      step($sformatf("rnd%0d", i), r, l, c, u, d, WIDTH'(nxt),
           model_tc(model, r, l, c, u));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/four_bit_up_down_counter.md
Name: four_bit_up_down_counter

Overview:
- Synchronous binary up/down counter. Default width is 4 bits.
- Supports synchronous reset, parallel load, hold, and count up or down with modulo wrap-around.
- Used as a general-purpose sequencing/count element.
- Provides a terminal-count flag so counters can be cascaded.

Parameters:
- WIDTH, 4, counter width in bits. Must be ≥ 1. All count arithmetic is modulo 2^WIDTH.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Load  input  1  parallel-load enable.
- Count_en  input  1  count enable.
- Up  input  1  direction: 1 = increment, 0 = decrement.
- Count_in  input  WIDTH  parallel-load data.
- Count_out  output  WIDTH  current count, driven directly from the register.
- Tc  output  1  terminal count, combinational.

Behaviour:
- Single clock domain. Single state register cnt[WIDTH-1:0]. Count_out = cnt.
- Reset is synchronous and active-high.
- On each rising edge of Clk, one action applies, in strict priority order:
  1. Reset = 1 → cnt <= 0. Overrides Load and Count_en.
  2. Load = 1 → cnt <= Count_in. Independent of Count_en and Up; loaded value appears on Count_out after the edge.
  3. Count_en = 1 and Up = 1 → cnt <= cnt + 1 modulo 2^WIDTH.
  4. Count_en = 1 and Up = 0 → cnt <= cnt − 1 modulo 2^WIDTH.
  5. Otherwise → cnt holds.
- Latency: one clock from input change to Count_out change. No combinational path from inputs to Count_out.
- Wrap-around:
  - Up from all-ones (4'b1111) gives 0 on the next edge.
  - Down from 0 gives all-ones (4'b1111) on the next edge.
  - No saturation, no error flag.
- Tc = Count_en & ~Load & ~Reset & ((Up & cnt == all-ones) | (~Up & cnt == 0)).
  - Tc is high exactly in the cycle before a wrap would occur.
- Direction change while counting takes effect on the next edge; no idle cycle is inserted.
- Reset asserted mid-count clears on the next edge; counting resumes from 0 on the first edge after Reset deasserts, if Count_en = 1.
- Load and Count_en both asserted: load wins; no increment is applied to the loaded value in that cycle.
- Initial value before the first reset is undefined for synthesis. Simulation may start at X; the bench must apply Reset first.
- No other state, FSM, or handshake.

Test Plan:
- Hold Reset = 1 for one edge with Count_en = 1 and Load = 1 → Count_out = 0 after the edge; Tc = 0.
- Load = 1, Count_in = 4'b1010 for one edge → Count_out = 10. Then Load = 0, Count_en = 0 for 3 edges → Count_out stays 10.
- Count_en = 1, Up = 1 for 16 edges from 10:
  - Sequence 11, 12, 13, 14, 15, 0, 1, …, 10.
  - Tc = 1 only while Count_out = 15.
- Count_en = 1, Up = 0 for 16 edges from 10:
  - Sequence 9, 8, …, 0, 15, 14, …, 10.
  - Tc = 1 only while Count_out = 0.
- Count_en = 1, Up = 1 at Count_out = 7, assert Load with Count_in = 4'b0011 → next Count_out = 3, not 8.
- Counting up at Count_out = 5, assert Reset for one edge → Count_out = 0. Deassert Reset → 1, 2, … on following edges.
